// File: rtl/mips_alu_muldiv_seq_pkg.sv
// Shared types for the multi-cycle HI/LO unit: function codes, FSM states, control bundle.
package mips_alu_muldiv_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

    typedef struct packed {
        logic clk;
        logic rst;
    } data_control_t;

    typedef enum logic [4:0] {
        FUNC_ADD  = 5'd0,
        FUNC_SUB  = 5'd1,
        FUNC_AND  = 5'd2,
        FUNC_OR   = 5'd3,
        FUNC_XOR  = 5'd4,
        FUNC_SLT  = 5'd5,
        FUNC_MULU = 5'd8,
        FUNC_MULS = 5'd9,
        FUNC_DIVU = 5'd10,
        FUNC_DIVS = 5'd11,
        FUNC_MTHI = 5'd12,
        FUNC_MTLO = 5'd13,
        FUNC_MFHI = 5'd14,
        FUNC_MFLO = 5'd15
    } alu_func_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    function automatic logic is_hilo_func(input alu_func_t f);
        return f inside {FUNC_MULU, FUNC_MULS, FUNC_DIVU, FUNC_DIVS,
                         FUNC_MTHI, FUNC_MTLO, FUNC_MFHI, FUNC_MFLO};
    endfunction

endpackage

// File: rtl/mips_alu_muldiv_seq_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on {acc,q}.
module mips_alu_muldiv_seq_step
    import mips_alu_muldiv_seq_pkg::*;
(
    input  logic              div_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] opnd_i,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W:0] sum_c;
    logic [DATA_W:0] shl_c;
    logic [DATA_W:0] diff_c;

    always_comb begin
        sum_c  = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
        shl_c  = {acc_i, q_i[DATA_W-1]};
        diff_c = shl_c - {1'b0, opnd_i};
        if (div_i) begin
            // Top bit of the difference is the borrow: set means restore.
            if (!diff_c[DATA_W]) begin
                acc_o = diff_c[DATA_W-1:0];
                q_o   = {q_i[DATA_W-2:0], 1'b1};
            end else begin
                acc_o = shl_c[DATA_W-1:0];
                q_o   = {q_i[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_o = sum_c[DATA_W:1];
            q_o   = {sum_c[0], q_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/mips_alu_muldiv_seq.sv
// Multi-cycle HI/LO unit: iterative mul/div, mthi/mtlo/mfhi/mflo, stall while busy.
module mips_alu_muldiv_seq
    import mips_alu_muldiv_seq_pkg::*;
(
    input  data_control_t     ctrl_i,
    input  logic              issue_i,
    input  alu_func_t         func_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o
);

    logic clk;
    logic rst;
    assign clk = ctrl_i.clk;
    assign rst = ctrl_i.rst;

    md_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] hi_q, lo_q, acc_q, q_q, opnd_q;
    logic              div_q, neg_res_q, neg_rem_q, dz_q, busy_q, done_q;

    logic [DATA_W-1:0] acc_step, q_step;

    mips_alu_muldiv_seq_step u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .q_i    (q_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step),
        .q_o    (q_step)
    );

    // Operand magnitudes and sign flags for the op being issued.
    logic              is_signed_c, a_neg_c, b_neg_c;
    logic [DATA_W-1:0] abs_a_c, abs_b_c;

    always_comb begin
        is_signed_c = (func_i == FUNC_MULS) || (func_i == FUNC_DIVS);
        a_neg_c     = is_signed_c && data1_i[DATA_W-1];
        b_neg_c     = is_signed_c && data2_i[DATA_W-1];
        abs_a_c     = a_neg_c ? DATA_W'(-data1_i) : data1_i;
        abs_b_c     = b_neg_c ? DATA_W'(-data2_i) : data2_i;
    end

    // Sign fixup applied in FIX; div-by-zero returns the dividend in HI.
    logic [2*DATA_W-1:0] mag_c, prod_c;
    logic [DATA_W-1:0]   fix_hi_c, fix_lo_c;

    always_comb begin
        mag_c  = {acc_q, q_q};
        prod_c = neg_res_q ? (2*DATA_W)'(-mag_c) : mag_c;
        if (dz_q) begin
            fix_hi_c = acc_q;
            fix_lo_c = '1;
        end else if (div_q) begin
            fix_lo_c = neg_res_q ? DATA_W'(-q_q) : q_q;
            fix_hi_c = neg_rem_q ? DATA_W'(-acc_q) : acc_q;
        end else begin
            fix_hi_c = prod_c[2*DATA_W-1:DATA_W];
            fix_lo_c = prod_c[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_i) begin
                        case (func_i)
                            FUNC_MULU, FUNC_MULS: begin
                                acc_q     <= '0;
                                q_q       <= abs_b_c;
                                opnd_q    <= abs_a_c;
                                div_q     <= 1'b0;
                                neg_res_q <= a_neg_c ^ b_neg_c;
                                neg_rem_q <= 1'b0;
                                dz_q      <= 1'b0;
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= ST_RUN;
                            end
                            FUNC_DIVU, FUNC_DIVS: begin
                                acc_q     <= (data2_i == '0) ? data1_i : '0;
                                q_q       <= abs_a_c;
                                opnd_q    <= abs_b_c;
                                div_q     <= 1'b1;
                                neg_res_q <= a_neg_c ^ b_neg_c;
                                neg_rem_q <= a_neg_c;
                                dz_q      <= (data2_i == '0);
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= (data2_i == '0) ? ST_FIX : ST_RUN;
                            end
                            FUNC_MTHI: hi_q <= data1_i;
                            FUNC_MTLO: lo_q <= data1_i;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_step;
                    q_q   <= q_step;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    hi_q    <= fix_hi_c;
                    lo_q    <= fix_lo_c;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (func_i)
            FUNC_MFHI: result_o = hi_q;
            FUNC_MFLO: result_o = lo_q;
            default:   result_o = '0;
        endcase
    end

    assign stall_o = issue_i && busy_q && is_hilo_func(func_i);
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_mips_alu_muldiv_seq.sv
// Randomized + directed bench for mips_alu_muldiv_seq against a 64-bit arithmetic model.
module tb_mips_alu_muldiv_seq;
    import mips_alu_muldiv_seq_pkg::*;

    localparam int unsigned W = DATA_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    data_control_t ctrl;
    logic          issue = 1'b0;
    alu_func_t     func = FUNC_ADD;
    logic [W-1:0]  d1 = '0, d2 = '0;
    logic [W-1:0]  result_o;
    logic          stall_o, busy_o, done_o;

    assign ctrl = {clk, rst};

    mips_alu_muldiv_seq dut (
        .ctrl_i   (ctrl),
        .issue_i  (issue),
        .func_i   (func),
        .data1_i  (d1),
        .data2_i  (d2),
        .result_o (result_o),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model state: architectural HI/LO, pending result, busy cycles left, done expectation.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;
    bit           m_done = 1'b0;

    alu_func_t ftbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_op(input alu_func_t f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        q = 0;
        r = 0;
        case (f)
            FUNC_MULU: return {32'b0, a} * {32'b0, b};
            FUNC_MULS: return 64'(sa * sb);
            FUNC_DIVU: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Compare current outputs, then advance the model across the coming clock edge.
    task automatic model_step();
        logic [63:0]  r;
        logic         exp_stall;
        logic [W-1:0] exp_res;
        if (chk_en) begin
            exp_stall = issue && (m_left > 0) && is_hilo_func(func);
            exp_res   = (func == FUNC_MFHI) ? m_hi : (func == FUNC_MFLO) ? m_lo : '0;
            chk("busy",   32'(busy_o),  32'(m_left > 0));
            chk("done",   32'(done_o),  32'(m_done));
            chk("stall",  32'(stall_o), 32'(exp_stall));
            chk("result", result_o,     exp_res);
        end
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (issue) begin
                case (func)
                    FUNC_MULU, FUNC_MULS, FUNC_DIVU, FUNC_DIVS: begin
                        r = model_op(func, d1, d2);
                        p_hi = r[63:32];
                        p_lo = r[31:0];
                        m_left = ((func == FUNC_DIVU || func == FUNC_DIVS) && d2 == 0) ? 1 : W + 1;
                    end
                    FUNC_MTHI: m_hi = d1;
                    FUNC_MTLO: m_lo = d1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cyc(input bit r, input bit iss, input alu_func_t f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        rst = r; issue = iss; func = f; d1 = a; d2 = b;
    endtask

    task automatic lit(input string name, input logic [W-1:0] exp);
        #2;
        chk(name, result_o, exp);
    endtask

    task automatic wait_idle(input string name, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 1'b0, FUNC_ADD, '0, '0);
            #2;
            if (!busy_o) return;
            nbusy++;
        end
        checks++;
        failures++;
        $display("FAIL %s: busy still high after 200 cycles", name);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return W'($urandom_range(0, 20));
            4: return W'(-$urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        bit found;
        ftbl = '{FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_SLT, FUNC_MULU,
                 FUNC_MULS, FUNC_DIVU, FUNC_DIVS, FUNC_MTHI, FUNC_MTLO, FUNC_MFHI, FUNC_MFLO};

        repeat (3) cyc(1'b1, 1'b0, FUNC_ADD, '0, '0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("reset_hi", 32'h0);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("reset_lo", 32'h0);

        // Mulu with mfhi held until it is accepted.
        cyc(1'b0, 1'b1, FUNC_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0);
            #2;
            if (!busy_o) found = 1'b1;
            else n++;
        end
        chk("mulu_busy_cycles", 32'(n), 32'd33);
        chk("mulu_hi_first_free", result_o, 32'hFFFFFFFE);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("mulu_lo", 32'h00000001);

        // Muls with a stalled mthi behind it.
        cyc(1'b0, 1'b1, FUNC_MULS, 32'hFFFFFFFD, 32'd7);
        cyc(1'b0, 1'b1, FUNC_MTHI, 32'h1234, '0);
        wait_idle("muls", n);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("muls_hi", 32'hFFFFFFFF);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("muls_lo", 32'hFFFFFFEB);

        cyc(1'b0, 1'b1, FUNC_DIVS, 32'hFFFFFFF9, 32'd2);
        wait_idle("divs_neg", n);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("divs_lo", 32'hFFFFFFFD);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("divs_hi", 32'hFFFFFFFF);

        cyc(1'b0, 1'b1, FUNC_DIVU, 32'd7, 32'd2);
        wait_idle("divu", n);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("divu_lo", 32'd3);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("divu_hi", 32'd1);

        cyc(1'b0, 1'b1, FUNC_DIVS, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("divs_ovf", n);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("divs_ovf_lo", 32'h80000000);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("divs_ovf_hi", 32'h0);

        cyc(1'b0, 1'b1, FUNC_DIVU, 32'd5, 32'd0);
        wait_idle("div_zero", n);
        chk("div_zero_busy_cycles", 32'(n), 32'd1);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("div_zero_hi", 32'd5);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("div_zero_lo", 32'hFFFFFFFF);

        cyc(1'b0, 1'b1, FUNC_MTHI, 32'hA5A5A5A5, '0);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("mthi_old_lo", 32'hFFFFFFFF);
        chk("mthi_no_stall", 32'(stall_o), 32'd0);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("mthi_hi", 32'hA5A5A5A5);

        // Reset in the middle of RUN aborts the op and clears HI/LO.
        cyc(1'b0, 1'b1, FUNC_MULU, 32'h12345678, 32'd9);
        repeat (10) cyc(1'b0, 1'b0, FUNC_ADD, '0, '0);
        cyc(1'b1, 1'b0, FUNC_ADD, '0, '0);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0); lit("abort_hi", 32'h0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("abort_lo", 32'h0);
        cyc(1'b0, 1'b1, FUNC_MULU, 32'd6, 32'd7);
        #2 chk("post_abort_accept_busy", 32'(busy_o), 32'd0);
        wait_idle("post_abort", n);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0); lit("post_abort_lo", 32'd42);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                ftbl[$urandom_range(0, 13)], pick_operand(), pick_operand());
        end

        wait_idle("drain", n);
        cyc(1'b0, 1'b1, FUNC_MFHI, '0, '0);
        cyc(1'b0, 1'b1, FUNC_MFLO, '0, '0);
        @(negedge clk);
        model_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
